// File: rtl/pdp8_brk_arb_pkg.sv
// Shared pdp8 sizes and the arbiter's state/owner encodings.
package pdp8_brk_arb_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DEV = 1'b1;
endpackage

// File: rtl/pdp8_brk_arb.sv
// Data-break arbiter: device-priority sharing of one memory port with the CPU,
// with a bounded device burst so a waiting CPU always gets through.
module pdp8_brk_arb
    import pdp8_brk_arb_pkg::*;
#(
    parameter int BRK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read_req,
    input  logic              cpu_write_req,
    input  logic [ADDR_W-1:0] cpu_ma,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dev_read_req,
    input  logic              dev_write_req,
    input  logic [ADDR_W-1:0] dev_ma,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_done,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_ma,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              brk_active
);
    localparam int CNT_W = $clog2(BRK_MAX + 1);

    arb_state_t        r_state, w_state_nxt;
    logic              r_owner;
    logic [CNT_W-1:0]  r_brk_cnt;
    logic              r_mem_rd, r_mem_wr, r_cpu_done, r_dev_done, r_brk;
    logic [ADDR_W-1:0] r_mem_ma;
    logic [DATA_W-1:0] r_mem_wdata, r_cpu_rdata, r_dev_rdata;

    logic w_cpu_req, w_dev_req, w_cnt_full, w_grant_dev, w_grant_cpu, w_grant_wr;

    assign w_cpu_req  = cpu_read_req | cpu_write_req;
    assign w_dev_req  = dev_read_req | dev_write_req;
    assign w_cnt_full = (r_brk_cnt == CNT_W'(BRK_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_dev = 1'b0;
        w_grant_cpu = 1'b0;
        w_grant_wr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A full burst count yields to a waiting CPU exactly once.
                w_grant_dev = w_dev_req && !(w_cnt_full && w_cpu_req);
                w_grant_cpu = w_cpu_req && !w_grant_dev;
                w_grant_wr  = w_grant_dev ? dev_write_req : cpu_write_req;
                if (w_grant_dev || w_grant_cpu)
                    w_state_nxt = ST_ACC;
            end
            ST_ACC:  if (mem_done) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_CPU;
            r_brk_cnt   <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_ma    <= '0;
            r_mem_wdata <= '0;
            r_cpu_done  <= 1'b0;
            r_dev_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dev_rdata <= '0;
            r_brk       <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dev_done <= 1'b0;

            if (w_grant_dev || w_grant_cpu) begin
                r_owner     <= w_grant_dev ? OWN_DEV : OWN_CPU;
                r_mem_ma    <= w_grant_dev ? dev_ma : cpu_ma;
                r_mem_wdata <= w_grant_dev ? dev_wdata : cpu_wdata;
                r_mem_wr    <= w_grant_wr;
                r_mem_rd    <= !w_grant_wr;
                r_brk       <= w_grant_dev;
            end

            if (r_state == ST_IDLE) begin
                if (w_grant_cpu || !w_cpu_req)
                    r_brk_cnt <= '0;
                else if (w_grant_dev && !w_cnt_full)
                    r_brk_cnt <= r_brk_cnt + CNT_W'(1);
            end

            if (r_state == ST_ACC && mem_done) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                if (r_owner == OWN_DEV) begin
                    r_dev_done <= 1'b1;
                    if (r_mem_rd) r_dev_rdata <= mem_rdata;
                end else begin
                    r_cpu_done <= 1'b1;
                    if (r_mem_rd) r_cpu_rdata <= mem_rdata;
                end
            end

            if (r_state == ST_RESP)
                r_brk <= 1'b0;
        end
    end

    assign mem_read_req  = r_mem_rd;
    assign mem_write_req = r_mem_wr;
    assign mem_ma        = r_mem_ma;
    assign mem_wdata     = r_mem_wdata;
    assign cpu_done      = r_cpu_done;
    assign cpu_rdata     = r_cpu_rdata;
    assign dev_done      = r_dev_done;
    assign dev_rdata     = r_dev_rdata;
    assign brk_active    = r_brk;
endmodule

// File: tb/tb_pdp8_brk_arb.sv
// Directed bench for pdp8_brk_arb: per-cycle vector table plus burst-limit and reset sequences.
module tb_pdp8_brk_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read_req, cpu_write_req, dev_read_req, dev_write_req;
    logic [14:0] cpu_ma, dev_ma, mem_ma;
    logic [11:0] cpu_wdata, dev_wdata, mem_wdata, cpu_rdata, dev_rdata, mem_rdata;
    logic        cpu_done, dev_done, mem_read_req, mem_write_req, mem_done, brk_active;

    always #5 clk = ~clk;

    pdp8_brk_arb #(.BRK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_req(cpu_read_req), .cpu_write_req(cpu_write_req),
        .cpu_ma(cpu_ma), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dev_read_req(dev_read_req), .dev_write_req(dev_write_req),
        .dev_ma(dev_ma), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_done(dev_done),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_ma(mem_ma), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .brk_active(brk_active)
    );

    typedef struct packed {
        logic        rst, crd, cwr;
        logic [14:0] cma;
        logic [11:0] cwd;
        logic        drd, dwr;
        logic [14:0] dma;
        logic [11:0] dwd;
        logic [11:0] mrdata;
        logic        mdn;
        logic [55:0] exp_o;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t tbl[23];

    function automatic vec_t mk(
        input logic rst, crd, cwr, input logic [14:0] cma, input logic [11:0] cwd,
        input logic drd, dwr, input logic [14:0] dma, input logic [11:0] dwd,
        input logic [11:0] mrdata, input logic mdn,
        input logic e_mrd, e_mwr, input logic [14:0] e_ma, input logic [11:0] e_wd,
        input logic e_cdn, input logic [11:0] e_crd,
        input logic e_ddn, input logic [11:0] e_drd, input logic e_brk);
        vec_t v;
        v.rst = rst; v.crd = crd; v.cwr = cwr; v.cma = cma; v.cwd = cwd;
        v.drd = drd; v.dwr = dwr; v.dma = dma; v.dwd = dwd;
        v.mrdata = mrdata; v.mdn = mdn;
        v.exp_o = {e_mrd, e_mwr, e_ma, e_wd, e_cdn, e_crd, e_ddn, e_drd, e_brk};
        return v;
    endfunction

    function automatic logic [55:0] outs();
        return {mem_read_req, mem_write_req, mem_ma, mem_wdata,
                cpu_done, cpu_rdata, dev_done, dev_rdata, brk_active};
    endfunction

    task automatic chk(input string nm, input logic [55:0] got, input logic [55:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    logic [5:0]  order;
    int          n_done;
    logic        saw_cpu_acc, got_done;
    logic [2:0]  cnt_at_cpu;

    initial begin
        reset = 1'b1; cpu_read_req = 0; cpu_write_req = 0; dev_read_req = 0; dev_write_req = 0;
        cpu_ma = '0; cpu_wdata = '0; dev_ma = '0; dev_wdata = '0; mem_rdata = '0; mem_done = 1'b1;

        // Outputs listed are those registered after the edge that samples the row's inputs.
        //          rst crd cwr cma       cwd      drd dwr dma       dwd      mrdata   mdn  mrd mwr ma        wd       cdn crdata   ddn drdata   brk
        tbl[0]  = mk(1, 0,0, 15'o0,     12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o0,     12'o0,    0, 12'o0,    0, 12'o0,    0);
        tbl[1]  = mk(0, 1,0, 15'o01234, 12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   1,0, 15'o01234, 12'o0,    0, 12'o0,    0, 12'o0,    0);
        tbl[2]  = mk(0, 1,0, 15'o01234, 12'o0,    0,0, 15'o0,     12'o0,    12'o7654, 1,   0,0, 15'o01234, 12'o0,    1, 12'o7654, 0, 12'o0,    0);
        tbl[3]  = mk(0, 1,0, 15'o01234, 12'o0,    0,0, 15'o0,     12'o0,    12'o7654, 1,   0,0, 15'o01234, 12'o0,    0, 12'o7654, 0, 12'o0,    0);
        tbl[4]  = mk(0, 0,0, 15'o0,     12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o01234, 12'o0,    0, 12'o7654, 0, 12'o0,    0);
        // device read+write together is a write; read data must stay put
        tbl[5]  = mk(0, 0,0, 15'o0,     12'o0,    1,1, 15'o00100, 12'o1111, 12'o0,    1,   0,1, 15'o00100, 12'o1111, 0, 12'o7654, 0, 12'o0,    1);
        tbl[6]  = mk(0, 0,0, 15'o0,     12'o0,    1,1, 15'o00100, 12'o1111, 12'o3333, 1,   0,0, 15'o00100, 12'o1111, 0, 12'o7654, 1, 12'o0,    1);
        tbl[7]  = mk(0, 0,0, 15'o0,     12'o0,    1,1, 15'o00100, 12'o1111, 12'o3333, 1,   0,0, 15'o00100, 12'o1111, 0, 12'o7654, 0, 12'o0,    0);
        tbl[8]  = mk(0, 0,0, 15'o0,     12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o00100, 12'o1111, 0, 12'o7654, 0, 12'o0,    0);
        // device write with three wait states
        tbl[9]  = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o0,    0,   0,1, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    1);
        tbl[10] = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o3333, 0,   0,1, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    1);
        tbl[11] = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o3333, 0,   0,1, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    1);
        tbl[12] = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o3333, 0,   0,1, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    1);
        tbl[13] = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o3333, 1,   0,0, 15'o17777, 12'o0525, 0, 12'o7654, 1, 12'o0,    1);
        tbl[14] = mk(0, 0,0, 15'o0,     12'o0,    0,1, 15'o17777, 12'o0525, 12'o0,    1,   0,0, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    0);
        tbl[15] = mk(0, 0,0, 15'o0,     12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o17777, 12'o0525, 0, 12'o7654, 0, 12'o0,    0);
        // simultaneous CPU and device reads: device first
        tbl[16] = mk(0, 1,0, 15'o00007, 12'o0,    1,0, 15'o00010, 12'o0,    12'o0,    1,   1,0, 15'o00010, 12'o0,    0, 12'o7654, 0, 12'o0,    1);
        tbl[17] = mk(0, 1,0, 15'o00007, 12'o0,    1,0, 15'o00010, 12'o0,    12'o1111, 1,   0,0, 15'o00010, 12'o0,    0, 12'o7654, 1, 12'o1111, 1);
        tbl[18] = mk(0, 1,0, 15'o00007, 12'o0,    1,0, 15'o00010, 12'o0,    12'o0,    1,   0,0, 15'o00010, 12'o0,    0, 12'o7654, 0, 12'o1111, 0);
        tbl[19] = mk(0, 1,0, 15'o00007, 12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   1,0, 15'o00007, 12'o0,    0, 12'o7654, 0, 12'o1111, 0);
        tbl[20] = mk(0, 1,0, 15'o00007, 12'o0,    0,0, 15'o0,     12'o0,    12'o2222, 1,   0,0, 15'o00007, 12'o0,    1, 12'o2222, 0, 12'o1111, 0);
        tbl[21] = mk(0, 1,0, 15'o00007, 12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o00007, 12'o0,    0, 12'o2222, 0, 12'o1111, 0);
        tbl[22] = mk(0, 0,0, 15'o0,     12'o0,    0,0, 15'o0,     12'o0,    12'o0,    1,   0,0, 15'o00007, 12'o0,    0, 12'o2222, 0, 12'o1111, 0);

        for (int i = 0; i < 23; i++) begin
            reset = tbl[i].rst; cpu_read_req = tbl[i].crd; cpu_write_req = tbl[i].cwr;
            cpu_ma = tbl[i].cma; cpu_wdata = tbl[i].cwd;
            dev_read_req = tbl[i].drd; dev_write_req = tbl[i].dwr;
            dev_ma = tbl[i].dma; dev_wdata = tbl[i].dwd;
            mem_rdata = tbl[i].mrdata; mem_done = tbl[i].mdn;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp_o);
        end

        // Burst limit: both held, expect D D D D C D (D=1, C=0).
        cpu_read_req = 1; cpu_ma = 15'o00001; dev_read_req = 1; dev_ma = 15'o00002;
        mem_done = 1; mem_rdata = 12'o4444;
        order = '0; n_done = 0; saw_cpu_acc = 0; cnt_at_cpu = 3'd7;
        for (int c = 0; c < 60 && n_done < 6; c++) begin
            @(posedge clk); #1;
            if (mem_read_req && mem_ma == 15'o00001 && !saw_cpu_acc) begin
                saw_cpu_acc = 1; cnt_at_cpu = dut.r_brk_cnt;
            end
            if (dev_done) begin order = {order[4:0], 1'b1}; n_done++; end
            if (cpu_done) begin order = {order[4:0], 1'b0}; n_done++; cpu_read_req = 0; end
        end
        chk("burst_order", 56'({n_done[7:0], order}), 56'({8'd6, 6'b111101}));
        chk("brk_cnt_after_cpu_grant", 56'({saw_cpu_acc, cnt_at_cpu}), 56'({1'b1, 3'd0}));
        chk("burst_cpu_rdata", 56'(cpu_rdata), 56'(12'o4444));
        got_done = 0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            @(posedge clk); #1;
            got_done = dev_done;
        end
        dev_read_req = 0;
        chk("burst_drain", 56'(got_done), 56'(1'b1));
        @(posedge clk); #1;

        // Reset while an access is waiting on memory.
        cpu_read_req = 1; cpu_ma = 15'o00003; mem_done = 0;
        @(posedge clk); #1;
        chk("rst_acc_entered", 56'({mem_read_req, mem_ma}), 56'({1'b1, 15'o00003}));
        reset = 1; cpu_read_req = 0;
        @(posedge clk); #1;
        chk("rst_outputs", outs(), 56'd0);
        reset = 0;
        @(posedge clk); #1;
        chk("rst_no_done", outs(), 56'd0);
        cpu_read_req = 1; cpu_ma = 15'o00005; mem_done = 1; mem_rdata = 12'o6060;
        got_done = 0;
        for (int c = 0; c < 8 && !got_done; c++) begin
            @(posedge clk); #1;
            got_done = cpu_done;
        end
        cpu_read_req = 0;
        chk("rst_recover_read", 56'({got_done, cpu_rdata, dev_done}), 56'({1'b1, 12'o6060, 1'b0}));
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
